// File: rtl/uart_loader_pkg.sv
// ============================================================================
//  Module  : uart_loader_pkg
//  Brief   : Shared state types and helpers for the UART word loader.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package uart_loader_pkg;

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        WRITE   = 1'b1
    } rx_state_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2,
        WAIT = 2'd3
    } tx_state_t;

    function automatic int bytes_per_word(input int word_w);
        return word_w / 8;
    endfunction

endpackage

`default_nettype wire

// File: rtl/circular_queue.sv
// ============================================================================
//  Module  : circular_queue
//  Brief   : Power-of-two FIFO with show-ahead read data.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module circular_queue #(
    parameter int Q_WIDTH = 8,
    parameter int Q_SIZE  = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               we,
    input  logic [Q_WIDTH-1:0] wdata,
    input  logic               re,
    output logic [Q_WIDTH-1:0] rdata,
    output logic               full,
    output logic               empty
);

    localparam int c_PTR_W = $clog2(Q_SIZE);

    logic [Q_WIDTH-1:0] r_mem [Q_SIZE];
    logic [c_PTR_W:0]   r_wptr;
    logic [c_PTR_W:0]   r_rptr;
    logic               w_push;
    logic               w_pop;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty  = (r_wptr == r_rptr);
    assign full   = (r_wptr[c_PTR_W] != r_rptr[c_PTR_W]) &&
                    (r_wptr[c_PTR_W-1:0] == r_rptr[c_PTR_W-1:0]);
    assign w_push = we && !full;
    assign w_pop  = re && !empty;
    assign rdata  = r_mem[r_rptr[c_PTR_W-1:0]];

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wptr[c_PTR_W-1:0]] <= wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push)
                r_wptr <= r_wptr + 1'b1;
            if (w_pop)
                r_rptr <= r_rptr + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/uart.sv
// ============================================================================
//  Module  : uart
//  Brief   : 8N1 UART; baud is the number of clocks per bit.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module uart (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [12:0] baud,
    input  logic        RX,
    output logic        TX,
    input  logic        trmt,
    input  logic [7:0]  tx_data,
    output logic        tx_done,
    output logic        rx_rdy,
    output logic [7:0]  rx_data,
    input  logic        clr_rx_rdy
);

    logic [9:0]  r_tx_shift;
    logic [3:0]  r_tx_bit;
    logic [12:0] r_tx_cnt;
    logic        r_tx_busy;

    // Idle shifter holds all ones so bit 0 doubles as the line level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_shift <= '1;
            r_tx_bit   <= '0;
            r_tx_cnt   <= '0;
            r_tx_busy  <= 1'b0;
            tx_done    <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            if (!r_tx_busy) begin
                if (trmt) begin
                    r_tx_shift <= {1'b1, tx_data, 1'b0};
                    r_tx_busy  <= 1'b1;
                    r_tx_bit   <= '0;
                    r_tx_cnt   <= '0;
                end
            end else if (r_tx_cnt == baud - 13'd1) begin
                r_tx_cnt   <= '0;
                r_tx_shift <= {1'b1, r_tx_shift[9:1]};
                if (r_tx_bit == 4'd9) begin
                    r_tx_busy <= 1'b0;
                    tx_done   <= 1'b1;
                end else begin
                    r_tx_bit <= r_tx_bit + 4'd1;
                end
            end else begin
                r_tx_cnt <= r_tx_cnt + 13'd1;
            end
        end
    end

    assign TX = r_tx_shift[0];

    logic [2:0]  r_rx_sync;
    logic        r_rx_busy;
    logic [12:0] r_rx_cnt;
    logic [3:0]  r_rx_bit;
    logic [7:0]  r_rx_shift;
    logic        w_rx_in;

    assign w_rx_in = r_rx_sync[2];

    // First countdown is half a bit so every later sample lands mid-bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_sync  <= '1;
            r_rx_busy  <= 1'b0;
            r_rx_cnt   <= '0;
            r_rx_bit   <= '0;
            r_rx_shift <= '0;
            rx_rdy     <= 1'b0;
            rx_data    <= '0;
        end else begin
            r_rx_sync <= {r_rx_sync[1:0], RX};
            if (clr_rx_rdy)
                rx_rdy <= 1'b0;
            if (!r_rx_busy) begin
                if (!w_rx_in) begin
                    r_rx_busy <= 1'b1;
                    r_rx_cnt  <= {1'b0, baud[12:1]};
                    r_rx_bit  <= '0;
                end
            end else if (r_rx_cnt == '0) begin
                r_rx_cnt <= baud - 13'd1;
                r_rx_bit <= r_rx_bit + 4'd1;
                if (r_rx_bit == 4'd0) begin
                    if (w_rx_in)
                        r_rx_busy <= 1'b0;
                end else if (r_rx_bit == 4'd9) begin
                    r_rx_busy <= 1'b0;
                    rx_rdy    <= 1'b1;
                    rx_data   <= r_rx_shift;
                end else begin
                    r_rx_shift <= {w_rx_in, r_rx_shift[7:1]};
                end
            end else begin
                r_rx_cnt <= r_rx_cnt - 13'd1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/uart_word_serializer.sv
// ============================================================================
//  Module  : uart_word_serializer
//  Brief   : Pops words from the TX queue and feeds them to the UART a byte
//            at a time in the byte order latched at pop.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_word_serializer
    import uart_loader_pkg::*;
#(
    parameter int WORD_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              msb_first,
    input  logic              q_empty,
    input  logic [WORD_W-1:0] q_rdata,
    output logic              q_pop,
    input  logic              tx_done,
    output logic              trmt,
    output logic [7:0]        tx_data,
    output logic              busy
);

    localparam int c_BYTES = bytes_per_word(WORD_W);
    localparam int c_CNT_W = $clog2(c_BYTES + 1);

    tx_state_t          r_state;
    tx_state_t          w_next;
    logic [WORD_W-1:0]  r_shift;
    logic               r_msb;
    logic [c_CNT_W-1:0] r_sent;
    logic               w_last;

    assign w_last = (r_sent == c_CNT_W'(c_BYTES));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (!q_empty) w_next = LOAD;
            LOAD:    w_next = WAIT;
            WAIT:    if (tx_done) w_next = w_last ? IDLE : SEND;
            SEND:    w_next = WAIT;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        q_pop = (r_state == IDLE) && !q_empty;
        trmt  = (r_state == LOAD) || (r_state == SEND);
        busy  = (r_state != IDLE);
    end

    // The shift happens on the way into SEND so tx_data is already the next
    // byte in the cycle trmt is raised.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift <= '0;
            r_msb   <= 1'b0;
            r_sent  <= '0;
        end else if (q_pop) begin
            r_shift <= q_rdata;
            r_msb   <= msb_first;
            r_sent  <= '0;
        end else if (r_state == LOAD) begin
            r_sent <= c_CNT_W'(1);
        end else if (r_state == SEND) begin
            r_sent <= r_sent + c_CNT_W'(1);
        end else if ((r_state == WAIT) && tx_done && !w_last) begin
            r_shift <= r_msb ? (r_shift << 8) : (r_shift >> 8);
        end
    end

    assign tx_data = r_msb ? r_shift[WORD_W-1 -: 8] : r_shift[7:0];

endmodule

`default_nettype wire

// File: rtl/uart_word_loader.sv
// ============================================================================
//  Module  : uart_word_loader
//  Brief   : Packs UART RX bytes into words written to an auto-incrementing
//            address; queues host-bound words and serialises them on TX.
//            Optional RX byte checksum: define UART_LOADER_CSUM_EN.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_word_loader
    import uart_loader_pkg::*;
#(
    parameter int WORD_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int ADDR_STEP = 1,
    parameter int TXQ_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_en,
    input  logic              msb_first,
    input  logic [12:0]       baud,
    input  logic              RX,
    output logic              TX,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [WORD_W-1:0] wr_data,
    output logic [ADDR_W-1:0] words_loaded,
    input  logic [WORD_W-1:0] tx_word,
    input  logic              tx_push,
    output logic              tx_full,
    output logic              tx_busy,
    output logic              tx_drop,
    output logic [7:0]        rx_csum
);

    localparam int c_BYTES = bytes_per_word(WORD_W);
    localparam int c_CNT_W = $clog2(c_BYTES + 1);

    logic              w_rx_rdy;
    logic [7:0]        w_rx_data;
    logic              w_clr_rx_rdy;
    logic              w_trmt;
    logic [7:0]        w_tx_data;
    logic              w_tx_done;
    logic              w_q_empty;
    logic              w_q_pop;
    logic [WORD_W-1:0] w_q_rdata;
    logic              w_ser_busy;

    uart u_uart (
        .clk        (clk),
        .rst_n      (rst_n),
        .baud       (baud),
        .RX         (RX),
        .TX         (TX),
        .trmt       (w_trmt),
        .tx_data    (w_tx_data),
        .tx_done    (w_tx_done),
        .rx_rdy     (w_rx_rdy),
        .rx_data    (w_rx_data),
        .clr_rx_rdy (w_clr_rx_rdy)
    );

    rx_state_t          r_rx_state;
    rx_state_t          w_rx_next;
    logic [WORD_W-1:0]  r_asm;
    logic [c_CNT_W-1:0] r_byte_cnt;
    logic [ADDR_W-1:0]  r_addr;
    logic [ADDR_W-1:0]  r_words;
    logic               w_accept;
    logic               w_last_byte;
    logic [WORD_W-1:0]  w_byte_ext;
    logic [WORD_W-1:0]  w_merged;

    assign w_last_byte = (r_byte_cnt == c_CNT_W'(c_BYTES - 1));
    assign w_byte_ext  = WORD_W'(w_rx_data);
    assign w_merged    = msb_first ? ((r_asm << 8) | w_byte_ext)
                                   : ((r_asm >> 8) | (w_byte_ext << (WORD_W - 8)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_rx_state <= COLLECT;
        else
            r_rx_state <= w_rx_next;
    end

    always_comb begin
        w_rx_next = r_rx_state;
        unique case (r_rx_state)
            COLLECT: if (w_rx_rdy && load_en && w_last_byte) w_rx_next = WRITE;
            WRITE:   w_rx_next = COLLECT;
            default: w_rx_next = COLLECT;
        endcase
    end

    // A byte arriving during WRITE is left pending in the UART until COLLECT.
    always_comb begin
        w_clr_rx_rdy = (r_rx_state == COLLECT) && w_rx_rdy;
        w_accept     = w_clr_rx_rdy && load_en;
        wr_en        = (r_rx_state == WRITE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_asm      <= '0;
            r_byte_cnt <= '0;
            r_addr     <= '0;
            r_words    <= '0;
        end else if (r_rx_state == WRITE) begin
            r_byte_cnt <= '0;
            if (load_en) begin
                r_addr  <= r_addr + ADDR_W'(ADDR_STEP);
                r_words <= r_words + ADDR_W'(1);
            end else begin
                r_addr  <= '0;
                r_words <= '0;
            end
        end else if (!load_en) begin
            r_addr     <= '0;
            r_words    <= '0;
            r_byte_cnt <= '0;
        end else if (w_accept) begin
            r_asm      <= w_merged;
            r_byte_cnt <= r_byte_cnt + c_CNT_W'(1);
        end
    end

    assign wr_addr      = r_addr;
    assign wr_data      = r_asm;
    assign words_loaded = r_words;

`ifdef UART_LOADER_CSUM_EN
    logic [7:0] r_csum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_csum <= 8'h00;
        else if (!load_en)
            r_csum <= 8'h00;
        else if (w_accept)
            r_csum <= r_csum + w_rx_data;
    end

    assign rx_csum = r_csum;
`else
    assign rx_csum = 8'h00;
`endif

    // A push against a full queue is refused even if a pop frees a slot now.
    assign tx_drop = tx_push && tx_full;

    circular_queue #(
        .Q_WIDTH (WORD_W),
        .Q_SIZE  (TXQ_DEPTH)
    ) u_txq (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (tx_push && !tx_full),
        .wdata (tx_word),
        .re    (w_q_pop),
        .rdata (w_q_rdata),
        .full  (tx_full),
        .empty (w_q_empty)
    );

    uart_word_serializer #(
        .WORD_W (WORD_W)
    ) u_ser (
        .clk       (clk),
        .rst_n     (rst_n),
        .msb_first (msb_first),
        .q_empty   (w_q_empty),
        .q_rdata   (w_q_rdata),
        .q_pop     (w_q_pop),
        .tx_done   (w_tx_done),
        .trmt      (w_trmt),
        .tx_data   (w_tx_data),
        .busy      (w_ser_busy)
    );

    assign tx_busy = w_ser_busy || !w_q_empty;

endmodule

`default_nettype wire

// File: doc/uart_word_loader.md
Name: uart_word_loader

Overview:
- Parametrised UART loader/monitor for the main FPGA. RX bytes are packed into WORD_W-bit words, each written to an auto-incrementing address while load_en is high.
- The TX side queues host-bound words in a FIFO and serialises each one as WORD_W/8 UART bytes.
- Generalises the fixed 32-bit loader with:
  - configurable word, address and queue sizes;
  - selectable byte order;
  - a configurable address stride;
  - overflow reporting.

Parameters:
- WORD_W, 32, data word width; must be a multiple of 8 and at least 8. BYTES = WORD_W/8.
- ADDR_W, 32, write-address width.
- ADDR_STEP, 1, address increment applied after each word write.
- TXQ_DEPTH, 8, TX FIFO depth in words; must be a power of two.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- load_en  in  1  enables RX word assembly; when low, forces address and byte count to 0
- msb_first  in  1  1 = first byte on the wire is the most significant (RX and TX)
- baud  in  13  UART baud divisor, passed through to UART
- RX  in  1  serial input
- TX  out  1  serial output
- wr_en  out  1  one-cycle pulse: a word is ready
- wr_addr  out  ADDR_W  target address, valid while wr_en is high
- wr_data  out  WORD_W  assembled word, valid while wr_en is high
- words_loaded  out  ADDR_W  count of words written since load_en last rose
- tx_word  in  WORD_W  word to send to the host
- tx_push  in  1  enqueue tx_word
- tx_full  out  1  TX FIFO full
- tx_busy  out  1  TX FSM not idle, or FIFO not empty
- tx_drop  out  1  one-cycle pulse: tx_push was rejected because the FIFO was full
- rx_csum  out  8  running byte checksum (see Optional Feature)

Behaviour:
- Reset values: wr_en=0, wr_addr=0, wr_data=0, words_loaded=0, tx_drop=0, tx_full=0, tx_busy=0, rx_csum=0, TX idle high, RX FSM in COLLECT, TX FSM in IDLE.
- RX FSM has two states: COLLECT and WRITE.
- COLLECT, when rx_rdy=1:
  - clr_rx_rdy pulses for one cycle.
  - If load_en=1, the byte is merged into the assembly register and byte_cnt increments.
  - If load_en=0, the byte is discarded.
- Merge rule:
  - msb_first=1: shift left, i.e. {data[WORD_W-9:0], byte}.
  - msb_first=0: shift right with the byte entering the top, i.e. {byte, data[WORD_W-1:8]}.
- When the byte just accepted is byte BYTES-1, go to WRITE.
- WRITE (one cycle):
  - wr_en=1, wr_addr = current address, wr_data = assembled word.
  - Next cycle: address += ADDR_STEP (modulo 2^ADDR_W), words_loaded += 1, byte_cnt=0, return to COLLECT.
- Latency: wr_en rises exactly 1 cycle after the cycle in which the final byte is accepted.
- A byte arriving during WRITE stays pending (rx_rdy held) and is taken the following cycle; no byte is lost.
- load_en low:
  - Address, byte_cnt and words_loaded clear synchronously.
  - Any partial word is discarded.
  - If load_en falls during WRITE, the pending write still completes, then everything clears.
- Address wrap: an increment from 2^ADDR_W - ADDR_STEP wraps silently.
- TX FIFO:
  - A push is accepted when tx_push=1 and tx_full=0.
  - When tx_push=1 and tx_full=1 the word is dropped and tx_drop pulses.
  - A push while full is dropped even if a pop occurs in the same cycle.
- TX FSM states: IDLE, LOAD, SEND, WAIT.
  - IDLE: if the FIFO is not empty, pop into the shift register and latch msb_first for this word; go to LOAD.
  - LOAD: present byte 0 (lowest byte if latched msb_first=0, else highest), trmt=1, sent=1; go to WAIT.
  - WAIT: on tx_done, if sent==BYTES go to IDLE; otherwise go to SEND.
  - SEND: shift the register by 8 toward the output byte, trmt=1, sent+=1; go to WAIT.
- TX output: tx_data always comes from the output end of the shift register.
- Mid-operation reset: all state and the FIFO return to reset values immediately; no partial byte is completed.

Optional Feature:
- Macro: UART_LOADER_CSUM_EN.
- Defined:
  - rx_csum holds the mod-256 sum of every byte accepted while load_en=1.
  - It clears when load_en=0.
  - It updates in the same cycle the byte is accepted.
- Undefined: rx_csum is tied to 8'h00 and no adder is synthesised.

Decomposition:
- Package uart_loader_pkg holds:
  - typedef rx_state_t {COLLECT, WRITE};
  - typedef tx_state_t {IDLE, LOAD, SEND, WAIT};
  - localparam function bytes_per_word(WORD_W).
- Instantiates the existing UART (baud passthrough) and circular_queue (Q_WIDTH=WORD_W, Q_SIZE=TXQ_DEPTH).
- One natural sub-module: uart_word_serializer (TX FSM plus shift register plus byte counter).

Test Plan:
- WORD_W=32, msb_first=1, load_en=1; RX 12 34 56 78 then 9A BC DE F0 -> wr_en pulses twice: (addr 0, 0x12345678) then (addr 1, 0x9ABCDEF0); words_loaded=2.
- msb_first=0, ADDR_STEP=4; RX 78 56 34 12 -> wr_data=0x12345678 at addr 0; next word lands at addr 4.
- load_en dropped after 2 of 4 bytes, then raised; RX AA BB CC DD -> single write 0xAABBCCDD at addr 0; the partial bytes never appear.
- Push 9 words with TXQ_DEPTH=8 while UART is busy -> the ninth push raises tx_drop for 1 cycle; 8 words, i.e. 32 bytes, emerge on TX in order; tx_busy falls after the last tx_done.
- Push 0x11223344 with msb_first=0 -> TX bytes 44 33 22 11; with msb_first=1 -> 11 22 33 44.
- Assert rst_n low mid-word on both paths -> all outputs return to reset values, TX line goes high, FIFO is empty; with UART_LOADER_CSUM_EN, RX 01 02 03 04 -> rx_csum=0x0A.
